// File: rtl/mux2t1_1_if.sv
// Signal bundle for the mux2t1_1 registered 2:1 selector: data sources,
// select request and the registered results (mux output, effective select, transition count).
interface mux2t1_1_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             s;
    logic [WIDTH-1:0] out;
    logic             sel_q;
    logic [CNT_W-1:0] swcnt;

    // master drives the sources and select, slave returns the registered results
    modport master (output i0, output i1, output s, input out, input sel_q, input swcnt);
    modport slave  (input i0, input i1, input s, output out, output sel_q, output swcnt);
endinterface

// File: rtl/mux2t1_1.sv
// Registered 2:1 selector with effective-select and saturating transition-count outputs.
// Define MUX2T1_1_SYNC_SEL_EN to pass s through a 2-flop synchronizer before use.
module mux2t1_1 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             s,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             rst,
    output logic             sel_q,
    output logic [CNT_W-1:0] swcnt
);

    logic             sel_e;
    logic             sel_d;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] swcnt_d;
    logic [CNT_W-1:0] swcnt_q;

`ifdef MUX2T1_1_SYNC_SEL_EN
    logic sync1_d;
    logic sync1_q;
    logic sync2_d;
    logic sync2_q;

    // synchronizer stage inputs
    always_comb begin
        sync1_d = s;
        sync2_d = sync1_q;
    end

    // two-flop synchronizer for an asynchronously driven select
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sel_e = sync2_q;
`else
    assign sel_e = s;
`endif

    // next output, effective select and saturating transition count
    always_comb begin
        out_d   = (sel_e ? I1 : I0);
        sel_d   = sel_e;
        swcnt_d = swcnt_q;
        if ((sel_e != sel_q) && (swcnt_q != {CNT_W{1'b1}})) begin
            swcnt_d = swcnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            swcnt_d = swcnt_q;
        end
    end

    // output registers; reset overrides any simultaneous input change
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= {WIDTH{1'b0}};
            sel_q   <= 1'b0;
            swcnt_q <= {CNT_W{1'b0}};
        end else begin
            out_q   <= out_d;
            sel_q   <= sel_d;
            swcnt_q <= swcnt_d;
        end
    end

    assign out   = out_q;
    assign swcnt = swcnt_q;

endmodule

// File: tb/tb_mux2t1_1.sv
// Directed self-checking bench for mux2t1_1 (WIDTH=4, CNT_W=2); select latency
// follows MUX2T1_1_SYNC_SEL_EN.
module tb_mux2t1_1;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;
`ifdef MUX2T1_1_SYNC_SEL_EN
    localparam int SEL_LAT = 3;
`else
    localparam int SEL_LAT = 1;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   exp_cnt;

    mux2t1_1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    mux2t1_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .I0    (bus.i0),
        .I1    (bus.i1),
        .s     (bus.s),
        .out   (bus.out),
        .clk   (clk),
        .rst   (rst),
        .sel_q (bus.sel_q),
        .swcnt (bus.swcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // reset held 2 edges with all inputs high
        rst = 1'b1; bus.i0 = 4'h1; bus.i1 = 4'h1; bus.s = 1'b1;
        step(2);
        check_eq("rst_out",   32'(bus.out),   32'h0);
        check_eq("rst_sel",   32'(bus.sel_q), 32'h0);
        check_eq("rst_cnt",   32'(bus.swcnt), 32'h0);

        // select 0
        rst = 1'b0; bus.i0 = 4'hA; bus.i1 = 4'h5; bus.s = 1'b0;
        step(1);
        check_eq("sel0_out",  32'(bus.out),   32'hA);
        check_eq("sel0_sel",  32'(bus.sel_q), 32'h0);
        check_eq("sel0_cnt",  32'(bus.swcnt), 32'h0);

        // select 1
        bus.s = 1'b1;
`ifdef MUX2T1_1_SYNC_SEL_EN
        step(2);
        check_eq("sync_hold_out", 32'(bus.out),   32'hA);
        check_eq("sync_hold_cnt", 32'(bus.swcnt), 32'h0);
        step(1);
`else
        step(1);
`endif
        check_eq("sel1_out",  32'(bus.out),   32'h5);
        check_eq("sel1_sel",  32'(bus.sel_q), 32'h1);
        check_eq("sel1_cnt",  32'(bus.swcnt), 32'h1);

        // data tracking with X on the unselected input
        bus.i0 = 'x; bus.i1 = 4'h3;
        step(1);
        check_eq("track_a",   32'(bus.out),   32'h3);
        bus.i1 = 4'hC;
        step(1);
        check_eq("track_b",   32'(bus.out),   32'hC);
        check_eq("track_cnt", 32'(bus.swcnt), 32'h1);

        // simultaneous select and data change
        bus.s = 1'b0; bus.i0 = 4'h6; bus.i1 = 4'h9;
        step(SEL_LAT);
        check_eq("simul_out", 32'(bus.out),   32'h6);
        check_eq("simul_sel", 32'(bus.sel_q), 32'h0);
        check_eq("simul_cnt", 32'(bus.swcnt), 32'h2);

        // mid-operation reset
        rst = 1'b1;
        step(1);
        check_eq("rst2_out",  32'(bus.out),   32'h0);
        check_eq("rst2_cnt",  32'(bus.swcnt), 32'h0);

        // saturation: 5 toggles on a 2-bit counter
        rst = 1'b0; bus.s = 1'b0;
        step(SEL_LAT);
        for (int i = 0; i < 5; i++) begin
            bus.s = ~bus.s;
            step(SEL_LAT);
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            check_eq("sat_cnt", 32'(bus.swcnt), 32'(exp_cnt));
            check_eq("sat_sel", 32'(bus.sel_q), 32'(bus.s));
        end
        step(2);
        check_eq("sat_hold",  32'(bus.swcnt), 32'h3);

        // reset clears the saturated counter, then first value after release
        rst = 1'b1;
        step(1);
        check_eq("rst3_cnt",  32'(bus.swcnt), 32'h0);
        check_eq("rst3_sel",  32'(bus.sel_q), 32'h0);
        rst = 1'b0; bus.s = 1'b0; bus.i0 = 4'hE; bus.i1 = 4'h1;
        step(1);
        check_eq("post_rst_out", 32'(bus.out), 32'hE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux2t1_1.md
# mux2t1_1

Registered 2:1 selector: on every clock edge the output register captures `I1` when the effective select is 1, else `I0`. It is a leaf datapath primitive used wherever a clean, glitch-free, clock-aligned choice between two sources is needed. It also exposes the effective select and a saturating count of select transitions for debug and coverage.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `I0`, `I1` and `out`.
- `CNT_W`, default 8: width of the `swcnt` transition counter.

Ports (clock and reset are synchronous to each other; reset is synchronous, active-high). Declaration order is `I0, I1, s, out, clk, rst, sel_q, swcnt`, so that positional 4-port connections still bind the data ports.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `I0`  in  WIDTH  data source selected when the effective select is 0.
- `I1`  in  WIDTH  data source selected when the effective select is 1.
- `s`  in  1  select request.
- `out`  out  WIDTH  registered mux output.
- `sel_q`  out  1  effective select used for the most recent `out` update.
- `swcnt`  out  CNT_W  saturating count of effective-select transitions since reset.

## Operation
- Effective select `sel_e`:
  - Without the sync feature, `sel_e` is `s` as sampled at the edge.
  - With the sync feature, `sel_e` is the output of the synchronizer (see Configuration).
- Each rising edge with `rst`=0:
  - `out` <= (`sel_e` ? `I1` : `I0`).
  - `sel_q` <= `sel_e`.
  - If `sel_e` != `sel_q` and `swcnt` != all-ones, `swcnt` <= `swcnt`+1.
  - At all-ones, `swcnt` holds (saturates; it never wraps).
- Rising edge with `rst`=1: `out`=0, `sel_q`=0, `swcnt`=0, and all synchronizer flops cleared to 0. Reset overrides any simultaneous data or select change.
- The first transition counted after reset is `sel_e` going 0->1, because `sel_q` resets to 0.
- X/Z on the unselected input must not affect `out`. X on `s` propagates per normal RTL semantics; no X-masking is performed.
- No combinational path exists from any input to any output.

## Timing
- Data latency: 1 clock from `I0`/`I1` to `out` (sync feature off or on).
- Select latency, sync feature off: 1 clock from `s` to `out`/`sel_q`.
- Select latency, sync feature on: 3 clocks (2 synchronizer stages plus the output register).
- `swcnt` updates on the same edge that `sel_q` changes.
- Reset mid-operation: outputs are 0 on the edge after `rst` is sampled high. The first non-reset value appears 1 edge (or 3 edges for select, with sync on) after `rst` is sampled low.
- Simultaneous select and data change at one edge: `out` takes the new select applied to the new data.

## Configuration
- Macro `MUX2T1_1_SYNC_SEL_EN`.
  - Defined: `s` passes through a 2-flop synchronizer (both flops reset to 0) before use as `sel_e`. This makes `s` safe to drive asynchronously.
  - Not defined: `s` is used directly as `sel_e`. In this case `s` must meet setup/hold to `clk`.
  - The data paths are identical in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `I0`=1, `I1`=1, `s`=1 -> `out`=0, `sel_q`=0, `swcnt`=0.
- Select 0, sync off: `I0`=1, `I1`=0, `s`=0 -> `out`=1 after 1 edge, `sel_q`=0, `swcnt`=0.
- Select 1, sync off: from the prior state set `s`=1 -> `out`=0 and `sel_q`=1 after 1 edge, `swcnt`=1.
- Data tracking: `s`=1, toggle `I1` 0->1 while `I0` is held X -> `out`=1 one edge later, no X on `out`.
- Sync on (`MUX2T1_1_SYNC_SEL_EN`): `s` 0->1 -> `out` switches from `I0` to `I1` exactly on the 3rd edge; `swcnt` increments on that same edge.
- Saturation: with `CNT_W`=2, toggle `s` 5 times -> `swcnt` reads 3 and holds; then assert `rst` -> `swcnt`=0 on the next edge.
